// File: rtl/mitll_dfft_toggle_decoder.sv
// rtl/mitll_dfft_toggle_decoder.sv - DFFT toggle-coded stream to WIDTH-bit words
// One toggle per SFQ clock window decodes as 1, none as 0; bits assembled LSB-first.
module mitll_dfft_toggle_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_evt,
    input  logic             tog_in,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             err_double,
    output logic             err_overflow,
    input  logic             err_clr
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {PRIME, RUN} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ref_lvl;
    logic [1:0]             tcount;
    logic [WIDTH-1:0]       shift_q;
    logic [CW-1:0]          bit_cnt;

    logic                   s;
    logic                   tog_evt;
    logic [1:0]             tc_eff;
    logic                   win_bit;
    logic                   closing;
    logic                   completing;
    logic [WIDTH-1:0]       assembled;

    // A toggle in the closing cycle still belongs to the window being closed.
    always_comb begin
        s          = sync_q[SYNC_STAGES-1];
        tog_evt    = (state == RUN) && (s != ref_lvl);
        tc_eff     = (tog_evt && tcount != 2'd2) ? tcount + 2'd1 : tcount;
        win_bit    = (tc_eff != 2'd0);
        closing    = (state == RUN) && clk_evt;
        completing = closing && (bit_cnt == CW'(WIDTH - 1));
        assembled  = shift_q;
        assembled[bit_cnt] = win_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= PRIME;
            sync_q       <= '0;
            ref_lvl      <= 1'b0;
            tcount       <= 2'd0;
            shift_q      <= '0;
            bit_cnt      <= '0;
            word_data    <= '0;
            word_valid   <= 1'b0;
            err_double   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], tog_in};
            ref_lvl <= s;

            // Clear first so an error event in the same cycle keeps its flag set.
            if (err_clr) begin
                err_double   <= 1'b0;
                err_overflow <= 1'b0;
            end

            case (state)
                PRIME: begin
                    tcount  <= 2'd0;
                    bit_cnt <= '0;
                    if (clk_evt) state <= RUN;
                end
                RUN: begin
                    if (closing) begin
                        tcount  <= 2'd0;
                        shift_q <= assembled;
                        if (tc_eff == 2'd2) err_double <= 1'b1;
                        if (completing) bit_cnt <= '0;
                        else            bit_cnt <= bit_cnt + CW'(1);
                    end else begin
                        tcount <= tc_eff;
                    end
                end
                default: state <= PRIME;
            endcase

            if (completing && (!word_valid || word_ready)) begin
                word_data  <= assembled;
                word_valid <= 1'b1;
            end else if (completing) begin
                err_overflow <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mitll_dfft_toggle_decoder.sv
// tb/tb_mitll_dfft_toggle_decoder.sv - scoreboard bench for mitll_dfft_toggle_decoder
module tb_mitll_dfft_toggle_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_evt = 1'b0;
    logic       tog_in = 1'b0;
    logic [7:0] word_data;
    logic       word_valid;
    logic       word_ready = 1'b0;
    logic       err_double;
    logic       err_overflow;
    logic       err_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    mitll_dfft_toggle_decoder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .clk_evt(clk_evt), .tog_in(tog_in),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .err_double(err_double), .err_overflow(err_overflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Each toggle is given time to clear the synchronizer before the window closes.
    task automatic window(input int ntog);
        for (int n = 0; n < ntog; n++) begin
            tog_in = ~tog_in;
            repeat (4) @(posedge clk);
            #1;
        end
        clk_evt = 1'b1;
        @(posedge clk);
        #1;
        clk_evt = 1'b0;
    endtask

    task automatic drive_bits(input logic [7:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) window(w[i] ? 1 : 0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tog_in = 1'b1; clk_evt = 1'b0; word_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", word_valid); end
        checks++; if (word_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", word_data); end
        checks++; if (err_double !== 1'b0) begin errors++; $display("FAIL rst_err_double got %b want 0", err_double); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL rst_err_overflow got %b want 0", err_overflow); end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        window(0);
        drive_bits(8'h00, 0, 6);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL prime_early_valid got %b want 0", word_valid); end
        window(0);
        exp_q.push_back(8'h00);
        check_word("prime_first_word");
        consume("prime_consume");
    endtask

    task automatic check_word(input string name);
        logic [7:0] e;
        checks++;
        if (word_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b want 1", name, word_valid); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s_scoreboard got empty want entry", name);
        end else begin
            e = exp_q.pop_front();
            if (word_data !== e) begin errors++; $display("FAIL %s_data got %h want %h", name, word_data, e); end
        end
    endtask

    task automatic consume(input string name);
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL %s_drop got %b want 0", name, word_valid); end
    endtask

    task automatic test_pattern;
        drive_bits(8'h85, 0, 7);
        exp_q.push_back(8'h85);
        check_word("pattern_85");
        checks++; if (err_double !== 1'b0) begin errors++; $display("FAIL pattern_err_double got %b want 0", err_double); end
        consume("pattern_consume");
    endtask

    task automatic test_double;
        drive_bits(8'h00, 0, 2);
        window(2);
        drive_bits(8'h00, 4, 7);
        exp_q.push_back(8'h08);
        check_word("double_word");
        checks++; if (err_double !== 1'b1) begin errors++; $display("FAIL double_flag got %b want 1", err_double); end
        consume("double_consume");
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checks++; if (err_double !== 1'b0) begin errors++; $display("FAIL double_clr got %b want 0", err_double); end
    endtask

    task automatic test_overflow;
        drive_bits(8'hA5, 0, 7);
        exp_q.push_back(8'hA5);
        drive_bits(8'h3C, 0, 7);
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", err_overflow); end
        check_word("ovf_hold");
        consume("ovf_consume");
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", err_overflow); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w2;
        w2 = 8'hC9;
        drive_bits(8'h96, 0, 7);
        exp_q.push_back(8'h96);
        drive_bits(w2, 0, 6);
        check_word("b2b_first");
        if (w2[7]) begin
            tog_in = ~tog_in;
            repeat (4) @(posedge clk);
            #1;
        end
        exp_q.push_back(w2);
        word_ready = 1'b1;
        clk_evt = 1'b1;
        @(posedge clk);
        #1;
        clk_evt = 1'b0;
        check_word("b2b_second");
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b want 0", err_overflow); end
        @(posedge clk);
        #1;
        word_ready = 1'b0;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b want 0", word_valid); end
    endtask

    task automatic test_reset_mid;
        drive_bits(8'hC3, 0, 7);
        drive_bits(8'h81, 0, 4);
        rst_n = 1'b0;
        #1;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", word_valid); end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        window(0);
        drive_bits(8'h5A, 0, 7);
        exp_q.push_back(8'h5A);
        check_word("midrst_word");
        consume("midrst_consume");
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_pattern();
        test_double();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
